conv2d_mem_ctrl: RTL and testbench

//  Memory-side endpoint for the conv2D accelerator's burst channels; sits directly downstream of the compute block.

---
 rtl/conv2d_mem_ctrl_pkg.sv | 17 +
 rtl/conv2d_mem_ctrl_skid_buf.sv | 56 +++++
 rtl/conv2d_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_conv2d_mem_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_mem_ctrl_pkg.sv
// Shared types and constants for the conv2d memory-side burst controller.
package conv2d_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WRESP = 2'd3
    } state_e;

    localparam int unsigned MEM_RD_LAT = 1;
    // Return buffer must absorb every beat that can be in flight behind a stalled consumer.
    localparam int unsigned SKID_DEPTH = MEM_RD_LAT + 1;
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int unsigned LEN_W      = 32;

endpackage

// File: rtl/conv2d_mem_ctrl_skid_buf.sv
// Two-entry valid/ready buffer on the SRAM read-return path; head entry drives the output.
module conv2d_mem_ctrl_skid_buf
    import conv2d_mem_ctrl_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    input  logic [DWIDTH-1:0]     in_data_i,
    output logic [DWIDTH-1:0]     out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [SKID_CNT_W-1:0] count_o
);

    logic [DWIDTH-1:0]     data0_q, data0_d;
    logic [DWIDTH-1:0]     data1_q, data1_d;
    logic [SKID_CNT_W-1:0] count_q, count_d;
    logic                  pop;

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = data0_q;
    assign count_o     = count_q;
    assign pop         = out_valid_o & out_ready_i;

    // Shift on pop, then place a pushed word in the first free slot.
    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        if (pop) begin
            data0_d = data1_q;
        end
        if (in_valid_i) begin
            if ((count_q == SKID_CNT_W'(0)) || ((count_q == SKID_CNT_W'(1)) && pop)) begin
                data0_d = in_data_i;
            end else begin
                data1_d = in_data_i;
            end
        end
        count_d = count_q + SKID_CNT_W'(in_valid_i) - SKID_CNT_W'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data0_q <= '0;
            data1_q <= '0;
            count_q <= '0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/conv2d_mem_ctrl.sv
// Memory-side burst endpoint: arbitrates read/write burst requests onto a single-port
// synchronous SRAM, streams read beats through a skid buffer and returns write responses.
module conv2d_mem_ctrl
    import conv2d_mem_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH     = 32,
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned MEM_AWIDTH = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [AWIDTH-1:0]     req_read_addr_i,
    input  logic                  req_read_addr_valid_i,
    output logic                  req_read_addr_ready_o,
    input  logic [LEN_W-1:0]      req_read_len_i,
    output logic [DWIDTH-1:0]     rdata_o,
    output logic                  rdata_valid_o,
    input  logic                  rdata_ready_i,
    input  logic [AWIDTH-1:0]     req_write_addr_i,
    input  logic                  req_write_addr_valid_i,
    output logic                  req_write_addr_ready_o,
    input  logic [LEN_W-1:0]      req_write_len_i,
    input  logic [DWIDTH-1:0]     req_write_data_i,
    input  logic                  req_write_data_valid_i,
    output logic                  req_write_data_ready_o,
    output logic                  resp_write_status_o,
    output logic                  resp_write_status_valid_o,
    input  logic                  resp_write_status_ready_i,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [MEM_AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0]     mem_din_o,
    input  logic [DWIDTH-1:0]     mem_dout_i
);

    state_e                state_q, state_d;
    logic [MEM_AWIDTH-1:0] base_q, base_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      issued_q, issued_d;
    logic [LEN_W-1:0]      done_q, done_d;
    logic                  last_read_q, last_read_d;
    logic                  inflight_q, issue;
    logic                  run_q;
    logic                  rd_pop;
    logic [SKID_CNT_W-1:0] skid_cnt;
    logic [2:0]            occ;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{req_read_addr_i[AWIDTH-1:MEM_AWIDTH+2], req_read_addr_i[1:0],
                                req_write_addr_i[AWIDTH-1:MEM_AWIDTH+2], req_write_addr_i[1:0]};

    assign resp_write_status_o = 1'b1;
    assign rd_pop              = rdata_valid_o & rdata_ready_i;
    // A beat leaving the buffer this cycle frees a slot for a same-cycle issue (zero bubble).
    assign occ                 = 3'(skid_cnt) + 3'(inflight_q) - 3'(rd_pop);

    conv2d_mem_ctrl_skid_buf #(.DWIDTH(DWIDTH)) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (inflight_q),
        .in_data_i   (mem_dout_i),
        .out_data_o  (rdata_o),
        .out_valid_o (rdata_valid_o),
        .out_ready_i (rdata_ready_i),
        .count_o     (skid_cnt)
    );

    always_comb begin
        state_d                   = state_q;
        base_d                    = base_q;
        len_d                     = len_q;
        issued_d                  = issued_q;
        done_d                    = done_q;
        last_read_d               = last_read_q;
        issue                     = 1'b0;
        req_read_addr_ready_o     = 1'b0;
        req_write_addr_ready_o    = 1'b0;
        req_write_data_ready_o    = 1'b0;
        resp_write_status_valid_o = 1'b0;
        mem_en_o                  = 1'b0;
        mem_we_o                  = 1'b0;
        mem_addr_o                = base_q + issued_q[MEM_AWIDTH-1:0];
        mem_din_o                 = req_write_data_i;

        case (state_q)
            ST_IDLE: begin
                if (run_q) begin
                    // Round-robin only matters on contention: the side served last yields.
                    req_read_addr_ready_o  = ~(req_write_addr_valid_i & last_read_q);
                    req_write_addr_ready_o = ~(req_read_addr_valid_i & ~last_read_q);
                    if (req_read_addr_valid_i && req_read_addr_ready_o) begin
                        base_d      = req_read_addr_i[MEM_AWIDTH+1:2];
                        len_d       = req_read_len_i;
                        done_d      = '0;
                        last_read_d = 1'b1;
                        state_d     = ST_READ;
                        // First SRAM read goes out on the fire cycle to hit the 2-cycle first beat.
                        issue       = (req_read_len_i != '0);
                        mem_addr_o  = req_read_addr_i[MEM_AWIDTH+1:2];
                        issued_d    = LEN_W'(issue);
                    end else if (req_write_addr_valid_i && req_write_addr_ready_o) begin
                        base_d      = req_write_addr_i[MEM_AWIDTH+1:2];
                        len_d       = req_write_len_i;
                        issued_d    = '0;
                        last_read_d = 1'b0;
                        state_d     = (req_write_len_i == '0) ? ST_WRESP : ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if ((issued_q < len_q) && (occ < 3'(SKID_DEPTH))) begin
                    issue    = 1'b1;
                    issued_d = issued_q + LEN_W'(1);
                end
                if (rd_pop) begin
                    done_d = done_q + LEN_W'(1);
                end
                if ((done_q + LEN_W'(rd_pop)) == len_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                req_write_data_ready_o = 1'b1;
                if (req_write_data_valid_i) begin
                    mem_we_o = 1'b1;
                    mem_en_o = 1'b1;
                    issued_d = issued_q + LEN_W'(1);
                    if ((issued_q + LEN_W'(1)) == len_q) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                resp_write_status_valid_o = 1'b1;
                if (resp_write_status_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            mem_en_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            done_q      <= '0;
            last_read_q <= 1'b0;
            inflight_q  <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            done_q      <= done_d;
            last_read_q <= last_read_d;
            inflight_q  <= issue;
            run_q       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv2d_mem_ctrl.sv
// Directed bench for conv2d_mem_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_conv2d_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd_addr = '0, rd_len = '0, wr_addr = '0, wr_len = '0, wr_data = '0;
    logic        rd_addr_valid = 0, rd_addr_ready, rdata_valid, rdata_ready = 0;
    logic        wr_addr_valid = 0, wr_addr_ready, wr_data_valid = 0, wr_data_ready;
    logic        resp_status, resp_valid, resp_ready = 0;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_din, mem_dout, rdata;
    logic [31:0] sram [0:16383];

    int n_total = 0;
    int n_pass  = 0;
    int en_cnt  = 0;

    always #5 clk = ~clk;

    conv2d_mem_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .req_read_addr_i(rd_addr), .req_read_addr_valid_i(rd_addr_valid),
        .req_read_addr_ready_o(rd_addr_ready), .req_read_len_i(rd_len),
        .rdata_o(rdata), .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready),
        .req_write_addr_i(wr_addr), .req_write_addr_valid_i(wr_addr_valid),
        .req_write_addr_ready_o(wr_addr_ready), .req_write_len_i(wr_len),
        .req_write_data_i(wr_data), .req_write_data_valid_i(wr_data_valid),
        .req_write_data_ready_o(wr_data_ready),
        .resp_write_status_o(resp_status), .resp_write_status_valid_o(resp_valid),
        .resp_write_status_ready_i(resp_ready),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_din_o(mem_din), .mem_dout_i(mem_dout)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            en_cnt <= en_cnt + 1;
            if (mem_we) sram[mem_addr] <= mem_din;
            else        mem_dout <= sram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic fire_read(input logic [31:0] addr, input logic [31:0] len);
        int w = 0;
        @(negedge clk);
        rd_addr = addr; rd_len = len; rd_addr_valid = 1'b1; rdata_ready = 1'b1;
        #1;
        while (!rd_addr_ready && w < 20) begin @(negedge clk); #1; w++; end
        check("rd_addr_ready", 32'(rd_addr_ready), 32'd1);
        @(posedge clk); #1 rd_addr_valid = 1'b0;
    endtask

    // Called right after the fire edge; cycle 1 is the cycle following the fire.
    task automatic collect_read(input int len, input bit toggle, input logic [31:0] first, input int stop);
        int cyc = 0, got = 0;
        while (got < stop && cyc < 100) begin
            @(negedge clk); cyc++;
            rdata_ready = toggle ? cyc[0] : 1'b1;
            #1;
            if (rdata_valid && rdata_ready) begin
                check("rd_data", rdata, first + 32'(got));
                if (!toggle) check("rd_cycle", 32'(cyc), 32'(2 + got));
                got++;
            end
        end
        check("rd_beats", 32'(got), 32'(stop));
        if (stop == len) begin
            @(negedge clk); #1;
            check("rd_drained", 32'(rdata_valid), 32'd0);
        end
        rdata_ready = 1'b0;
    endtask

    task automatic fire_write(input logic [31:0] addr, input logic [31:0] len);
        int w = 0;
        @(negedge clk);
        wr_addr = addr; wr_len = len; wr_addr_valid = 1'b1;
        #1;
        while (!wr_addr_ready && w < 20) begin @(negedge clk); #1; w++; end
        check("wr_addr_ready", 32'(wr_addr_ready), 32'd1);
        @(posedge clk); #1 wr_addr_valid = 1'b0;
    endtask

    task automatic send_wdata(input logic [31:0] d);
        int w = 0;
        @(negedge clk);
        wr_data = d; wr_data_valid = 1'b1;
        #1;
        while (!wr_data_ready && w < 20) begin @(negedge clk); #1; w++; end
        check("wr_data_ready", 32'(wr_data_ready), 32'd1);
        @(posedge clk); #1 wr_data_valid = 1'b0;
    endtask

    task automatic take_resp();
        int w = 0;
        @(negedge clk); #1;
        while (!resp_valid && w < 20) begin @(negedge clk); #1; w++; end
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_status", 32'(resp_status), 32'd1);
        repeat (2) @(negedge clk);
        #1 check("resp_held", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        @(negedge clk); #1;
        check("resp_single", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int e0;
        for (int i = 0; i < 9; i++) sram[i] = 32'(i + 1);
        mem_dout = '0;
        #2;
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_rd_ready", 32'(rd_addr_ready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Streaming read, consumer always ready
        e0 = en_cnt;
        fire_read(32'h0, 32'd9);
        collect_read(9, 1'b0, 32'd1, 9);
        check("rd9_mem_en", 32'(en_cnt - e0), 32'd9);

        // Back-pressured read
        e0 = en_cnt;
        fire_read(32'h0, 32'd9);
        collect_read(9, 1'b1, 32'd1, 9);
        check("rd9bp_mem_en", 32'(en_cnt - e0), 32'd9);

        // Write burst to words 64..67
        #1 check("wdata_ready_idle", 32'(wr_data_ready), 32'd0);
        e0 = en_cnt;
        fire_write(32'h100, 32'd4);
        send_wdata(32'hA); send_wdata(32'hB); send_wdata(32'hC); send_wdata(32'hD);
        take_resp();
        check("wr_mem_en", 32'(en_cnt - e0), 32'd4);
        for (int i = 0; i < 4; i++) check("wr_sram", sram[64 + i], 32'hA + 32'(i));

        // Zero-length bursts
        e0 = en_cnt;
        fire_read(32'h0, 32'd0);
        repeat (3) @(negedge clk);
        #1 check("rd0_no_beat", 32'(rdata_valid), 32'd0);
        fire_write(32'h40, 32'd0);
        take_resp();
        check("len0_mem_en", 32'(en_cnt - e0), 32'd0);

        // Arbitration after reset: read first, then write
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        rd_addr = 32'h0; rd_len = 32'd1; wr_addr = 32'h200; wr_len = 32'd1;
        rd_addr_valid = 1'b1; wr_addr_valid = 1'b1; rdata_ready = 1'b1;
        #1;
        check("arb1_rd_ready", 32'(rd_addr_ready), 32'd1);
        check("arb1_wr_ready", 32'(wr_addr_ready), 32'd0);
        @(posedge clk); #1 begin rd_addr_valid = 1'b0; wr_addr_valid = 1'b0; end
        collect_read(1, 1'b0, 32'd1, 1);
        @(negedge clk);
        rd_addr_valid = 1'b1; wr_addr_valid = 1'b1;
        #1;
        check("arb2_rd_ready", 32'(rd_addr_ready), 32'd0);
        check("arb2_wr_ready", 32'(wr_addr_ready), 32'd1);
        @(posedge clk); #1 begin rd_addr_valid = 1'b0; wr_addr_valid = 1'b0; end
        send_wdata(32'hCAFE);
        take_resp();
        check("arb2_sram", sram[128], 32'hCAFE);

        // Reset in the middle of a read burst
        fire_read(32'h0, 32'd9);
        collect_read(9, 1'b0, 32'd1, 3);
        rst = 1'b1;
        #1;
        check("abort_rdata_valid", 32'(rdata_valid), 32'd0);
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_rd_ready", 32'(rd_addr_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fire_read(32'h10, 32'd3);
        collect_read(3, 1'b0, 32'd5, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'(n_total), 32'd0);
        $fatal(1, "timeout");
    end

endmodule
